// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int MAX_CLIENT = 4;
  localparam int SD_AW      = 21;
  localparam int IDX_W      = 2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner select with optional fixed priority for client 0.
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NCLIENT = 3
) (
  input  logic [NCLIENT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               prio0,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [MAX_CLIENT-1:0] req_ext;
  logic [IDX_W:0]        pos;

  // Scan from the farthest slot down to ptr so the nearest requester wins last.
  always_comb begin
    req_ext              = '0;
    req_ext[NCLIENT-1:0] = req;
    pos                  = '0;
    gnt_idx              = '0;
    any                  = |req;
    for (int i = NCLIENT - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(NCLIENT)) pos = pos - (IDX_W + 1)'(NCLIENT);
      if (req_ext[pos[IDX_W-1:0]]) gnt_idx = pos[IDX_W-1:0];
    end
    if (prio0 && req[0]) gnt_idx = '0;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one toggle-handshake SDRAM port among NCLIENT level-request clients.
//   state | meaning
//   DRAIN | wait for an outstanding ack after reset, no client response
//   IDLE  | pick a winner, latch its access and toggle sd_req
//   WAIT  | access in flight until sd_ack matches sd_req
//   DONE  | one-cycle cl_done pulse, then back to IDLE
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NCLIENT = 3,
  parameter int PRIO0   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NCLIENT-1:0]             cl_req,
  input  logic [NCLIENT-1:0]             cl_we,
  input  logic [NCLIENT-1:0][SD_AW-1:0]  cl_a,
  input  logic [NCLIENT-1:0][1:0]        cl_ds,
  input  logic [NCLIENT-1:0][15:0]       cl_d,
  output logic [15:0]                    cl_q,
  output logic [NCLIENT-1:0]             cl_done,
  output logic                           sd_req,
  input  logic                           sd_ack,
  output logic                           sd_we,
  output logic [SD_AW:1]                 sd_a,
  output logic [1:0]                     sd_ds,
  output logic [15:0]                    sd_d,
  input  logic [15:0]                    sd_q
);

  localparam logic PRIO0_EN = (PRIO0 != 0);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NCLIENT-1:0] done_q, done_d;
  logic [15:0]        rdat_q, rdat_d;
  logic               sd_we_q, sd_we_d;
  logic [SD_AW-1:0]   sd_a_q, sd_a_d;
  logic [1:0]         sd_ds_q, sd_ds_d;
  logic [15:0]        sd_d_q, sd_d_d;
  // Toggle parity must survive reset, so this flop only has a power-up value.
  logic               sd_req_q = 1'b0;
  logic               sd_req_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               acked;

  rr_picker #(.NCLIENT(NCLIENT)) u_pick (
    .req     (cl_req),
    .ptr     (rr_ptr_q),
    .prio0   (PRIO0_EN),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign acked = (sd_ack == sd_req_q);

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    done_d   = '0;
    rdat_d   = rdat_q;
    sd_req_d = sd_req_q;
    sd_we_d  = sd_we_q;
    sd_a_d   = sd_a_q;
    sd_ds_d  = sd_ds_q;
    sd_d_d   = sd_d_q;
    case (state_q)
      DRAIN: if (acked) state_d = IDLE;
      IDLE: begin
        if (pick_any) begin
          g_d      = pick_idx;
          sd_we_d  = cl_we[pick_idx];
          sd_a_d   = cl_a[pick_idx];
          sd_ds_d  = cl_ds[pick_idx];
          sd_d_d   = cl_d[pick_idx];
          sd_req_d = ~sd_req_q;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (acked) begin
          if (!sd_we_q) rdat_d = sd_q;
          done_d[g_q] = 1'b1;
          rr_ptr_d    = (g_q == IDX_W'(NCLIENT - 1)) ? '0 : g_q + IDX_W'(1);
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DRAIN;
      g_q      <= '0;
      rr_ptr_q <= '0;
      done_q   <= '0;
      rdat_q   <= '0;
      sd_we_q  <= 1'b0;
      sd_a_q   <= '0;
      sd_ds_q  <= '0;
      sd_d_q   <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
      done_q   <= done_d;
      rdat_q   <= rdat_d;
      sd_we_q  <= sd_we_d;
      sd_a_q   <= sd_a_d;
      sd_ds_q  <= sd_ds_d;
      sd_d_q   <= sd_d_d;
      sd_req_q <= sd_req_d;
    end
  end

  assign cl_q    = rdat_q;
  assign cl_done = done_q;
  assign sd_req  = sd_req_q;
  assign sd_we   = sd_we_q;
  assign sd_a    = sd_a_q;
  assign sd_ds   = sd_ds_q;
  assign sd_d    = sd_d_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: two arbiters (round-robin and client-0 priority), each with a toggle-ack SDRAM model.
module tb_sdram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]        req_v  [2];
  logic [2:0]        done_v [2];
  logic [15:0]       clq_v  [2];
  logic              sdreq_v[2];
  logic              sdack_v[2] = '{1'b0, 1'b0};
  logic              sdwe_v [2];
  logic [20:0]       sda_v  [2];
  logic [1:0]        sdds_v [2];
  logic [15:0]       sdd_v  [2];
  logic [15:0]       sdq_v  [2] = '{16'h0, 16'h0};
  logic [2:0]        we;
  logic [2:0][20:0]  a;
  logic [2:0][1:0]   ds;
  logic [2:0][15:0]  d;

  sdram_arbiter #(.NCLIENT(3), .PRIO0(0)) dut (
    .clk(clk), .reset(reset), .cl_req(req_v[0]), .cl_we(we), .cl_a(a), .cl_ds(ds), .cl_d(d),
    .cl_q(clq_v[0]), .cl_done(done_v[0]), .sd_req(sdreq_v[0]), .sd_ack(sdack_v[0]),
    .sd_we(sdwe_v[0]), .sd_a(sda_v[0]), .sd_ds(sdds_v[0]), .sd_d(sdd_v[0]), .sd_q(sdq_v[0])
  );

  sdram_arbiter #(.NCLIENT(3), .PRIO0(1)) dut_p (
    .clk(clk), .reset(reset), .cl_req(req_v[1]), .cl_we(we), .cl_a(a), .cl_ds(ds), .cl_d(d),
    .cl_q(clq_v[1]), .cl_done(done_v[1]), .sd_req(sdreq_v[1]), .sd_ack(sdack_v[1]),
    .sd_we(sdwe_v[1]), .sd_a(sda_v[1]), .sd_ds(sdds_v[1]), .sd_d(sdd_v[1]), .sd_q(sdq_v[1])
  );

  // SDRAM model: ack (and read data) 'delay' edges after a toggle is seen.
  int          delay = 6;
  logic [15:0] rdata = 16'hBEEF;
  logic        m_prev[2] = '{1'b0, 1'b0};
  int          m_cnt [2] = '{0, 0};
  int          nacc  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sdreq_v[k] !== m_prev[k]) begin
        m_prev[k] <= sdreq_v[k];
        m_cnt[k]  <= delay;
        nacc[k]   <= nacc[k] + 1;
      end else if (m_cnt[k] > 1) begin
        m_cnt[k] <= m_cnt[k] - 1;
      end else if (m_cnt[k] == 1) begin
        m_cnt[k]   <= 0;
        sdack_v[k] <= m_prev[k];
        sdq_v[k]   <= rdata;
      end
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          glog[$];
  logic [15:0] qlog[$];

  function automatic int gat(input int i);
    return (glog.size() > i) ? glog[i] : -1;
  endfunction

  function automatic logic [15:0] qat(input int i);
    return (qlog.size() > i) ? qlog[i] : 16'hxxxx;
  endfunction

  // Log cl_done pulses on DUT k; clients drop req on done, client 0 re-raises until served redo0 times.
  task automatic collect(input int k, input int n, input int budget, input int redo0);
    int served0 = 0;
    bit raise = 1'b0;
    glog.delete();
    qlog.delete();
    for (int c = 0; c < budget && glog.size() < n; c++) begin
      @(negedge clk);
      if (raise) begin
        req_v[k][0] = 1'b1;
        raise = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (done_v[k][i]) begin
          glog.push_back(i);
          qlog.push_back(clq_v[k]);
          req_v[k][i] = 1'b0;
          if (i == 0) begin
            served0++;
            if (served0 < redo0) raise = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (done_v[0] !== 3'b000) begin n_bad++; $display("FAIL reset_done got=%b exp=000", done_v[0]); end
    n_cmp++; if (clq_v[0] !== 16'h0) begin n_bad++; $display("FAIL reset_cl_q got=%h exp=0000", clq_v[0]); end
    n_cmp++; if ({sdwe_v[0], sda_v[0], sdds_v[0], sdd_v[0]} !== 40'h0) begin
      n_bad++; $display("FAIL reset_sd_outs we=%b a=%h ds=%b d=%h exp=all zero", sdwe_v[0], sda_v[0], sdds_v[0], sdd_v[0]);
    end
    n_cmp++; if (sdreq_v[0] !== 1'b0) begin n_bad++; $display("FAIL reset_sd_req got=%b exp=0", sdreq_v[0]); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int extra = 0;
    delay = 6; rdata = 16'hBEEF;
    a[1] = 21'h012345; we[1] = 1'b0;
    req_v[0] = 3'b010;
    @(negedge clk);
    n_cmp++; if (sdreq_v[0] !== 1'b1) begin n_bad++; $display("FAIL read_sd_req_toggle got=%b exp=1", sdreq_v[0]); end
    n_cmp++; if (sda_v[0] !== 21'h012345) begin n_bad++; $display("FAIL read_sd_a got=%h exp=012345", sda_v[0]); end
    n_cmp++; if (sdwe_v[0] !== 1'b0) begin n_bad++; $display("FAIL read_sd_we got=%b exp=0", sdwe_v[0]); end
    collect(0, 1, 40, 0);
    n_cmp++; if (gat(0) !== 1) begin n_bad++; $display("FAIL read_done_client got=%0d exp=1", gat(0)); end
    n_cmp++; if (qat(0) !== 16'hBEEF) begin n_bad++; $display("FAIL read_cl_q got=%h exp=beef", qat(0)); end
    repeat (6) begin
      @(negedge clk);
      if (done_v[0] !== 3'b000) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL read_single_pulse extra=%0d exp=0", extra); end
  endtask

  task automatic test_round_robin();
    do_reset();
    delay = 3; rdata = 16'hBEEF;
    a[0] = 21'h000100; a[1] = 21'h000200; a[2] = 21'h000300;
    we = 3'b000;
    req_v[0] = 3'b111;
    collect(0, 3, 100, 0);
    n_cmp++; if ({gat(0), gat(1), gat(2)} !== {32'd0, 32'd1, 32'd2}) begin
      n_bad++; $display("FAIL rr_order_ptr0 got=%0d,%0d,%0d exp=0,1,2", gat(0), gat(1), gat(2));
    end
    n_cmp++; if (qat(2) !== 16'hBEEF) begin n_bad++; $display("FAIL rr_cl_q got=%h exp=beef", qat(2)); end
    req_v[0] = 3'b010;
    collect(0, 1, 40, 0);
    n_cmp++; if (gat(0) !== 1) begin n_bad++; $display("FAIL rr_single_c1 got=%0d exp=1", gat(0)); end
    req_v[0] = 3'b111;
    collect(0, 3, 100, 0);
    n_cmp++; if ({gat(0), gat(1), gat(2)} !== {32'd2, 32'd0, 32'd1}) begin
      n_bad++; $display("FAIL rr_order_ptr2 got=%0d,%0d,%0d exp=2,0,1", gat(0), gat(1), gat(2));
    end
  endtask

  task automatic test_prio0();
    delay = 3;
    req_v[1] = 3'b101;
    collect(1, 4, 200, 3);
    n_cmp++; if ({gat(0), gat(1), gat(2), gat(3)} !== {32'd0, 32'd0, 32'd0, 32'd2}) begin
      n_bad++; $display("FAIL prio0_order got=%0d,%0d,%0d,%0d exp=0,0,0,2", gat(0), gat(1), gat(2), gat(3));
    end
  endtask

  task automatic test_write();
    delay = 3; rdata = 16'h1111;
    a[2] = 21'h1ABCD; we[2] = 1'b1; ds[2] = 2'b10; d[2] = 16'h5A00;
    req_v[0] = 3'b100;
    @(negedge clk);
    n_cmp++; if ({sdwe_v[0], sdds_v[0], sdd_v[0]} !== {1'b1, 2'b10, 16'h5A00}) begin
      n_bad++; $display("FAIL write_sd_fields we=%b ds=%b d=%h exp=1,10,5a00", sdwe_v[0], sdds_v[0], sdd_v[0]);
    end
    n_cmp++; if (sda_v[0] !== 21'h1ABCD) begin n_bad++; $display("FAIL write_sd_a got=%h exp=1abcd", sda_v[0]); end
    collect(0, 1, 40, 0);
    n_cmp++; if (gat(0) !== 2) begin n_bad++; $display("FAIL write_done_client got=%0d exp=2", gat(0)); end
    n_cmp++; if (qat(0) !== 16'hBEEF) begin n_bad++; $display("FAIL write_cl_q_kept got=%h exp=beef", qat(0)); end
    we[2] = 1'b0; ds[2] = 2'b11;
  endtask

  task automatic test_reset_mid_access();
    int nb;
    int dn = 0;
    delay = 5; rdata = 16'hCAFE;
    nb = nacc[0];
    req_v[0] = 3'b001;
    @(negedge clk);
    @(negedge clk);
    req_v[0] = 3'b000;
    reset = 1'b1;
    @(negedge clk);
    if (done_v[0] !== 3'b000) dn++;
    reset = 1'b0;
    req_v[0] = 3'b010;
    repeat (4) begin
      @(negedge clk);
      if (done_v[0] !== 3'b000) dn++;
    end
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL drain_no_done count=%0d exp=0", dn); end
    n_cmp++; if (nacc[0] !== nb + 1) begin n_bad++; $display("FAIL drain_holds accesses=%0d exp=%0d", nacc[0] - nb, 1); end
    collect(0, 1, 60, 0);
    n_cmp++; if (gat(0) !== 1) begin n_bad++; $display("FAIL after_drain_client got=%0d exp=1", gat(0)); end
    n_cmp++; if (qat(0) !== 16'hCAFE) begin n_bad++; $display("FAIL after_drain_cl_q got=%h exp=cafe", qat(0)); end
    n_cmp++; if (nacc[0] !== nb + 2) begin n_bad++; $display("FAIL after_drain_accesses got=%0d exp=2", nacc[0] - nb); end
  endtask

  task automatic test_back_to_back();
    int nb;
    bit seen = 1'b0;
    delay = 3; rdata = 16'hBEEF;
    nb = nacc[0];
    req_v[0] = 3'b001;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done_v[0][0]) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL hold_first_done got=none exp=pulse"); end
    @(negedge clk);
    @(negedge clk);
    req_v[0] = 3'b000;
    collect(0, 1, 40, 0);
    n_cmp++; if (gat(0) !== 0) begin n_bad++; $display("FAIL hold_second_done got=%0d exp=0", gat(0)); end
    n_cmp++; if (nacc[0] !== nb + 2) begin n_bad++; $display("FAIL hold_accesses got=%0d exp=2", nacc[0] - nb); end
    nb = nacc[0];
    req_v[0] = 3'b001;
    collect(0, 1, 40, 0);
    collect(0, 1, 15, 0);
    n_cmp++; if (glog.size() !== 0) begin n_bad++; $display("FAIL clean_no_dup got=%0d dones exp=0", glog.size()); end
    n_cmp++; if (nacc[0] !== nb + 1) begin n_bad++; $display("FAIL clean_accesses got=%0d exp=1", nacc[0] - nb); end
  endtask

  initial begin
    req_v[0] = 3'b000;
    req_v[1] = 3'b000;
    we = 3'b000;
    a  = '0;
    ds = {2'b11, 2'b11, 2'b11};
    d  = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_prio0();
    test_write();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single toggle-handshake SDRAM port (one outstanding 16-bit access, `req`/`ack` toggle protocol) among `NCLIENT` requesters such as CPU, video fetch and ROM loader. Clients use a level request / one-cycle done pulse. The arbiter grants round-robin, with an optional strict priority for client 0, and runs exactly one SDRAM access at a time. It sits between the system bus muxing and the SDRAM controller, in the same `clk` domain.

## Interface
Parameters:
- `NCLIENT`, 3: number of requesters (2..4).
- `PRIO0`, 0: 1 means client 0 wins whenever it requests; 0 means pure round-robin.

Ports:
- `clk`  in  1: clock, same clock as the SDRAM controller.
- `reset`  in  1: synchronous, active-high.
- `cl_req`  in  NCLIENT: level request. Held with its inputs stable until `cl_done`.
- `cl_we`  in  NCLIENT: 1 = write.
- `cl_a`  in  NCLIENT×21: word address [21:1].
- `cl_ds`  in  NCLIENT×2: byte enables {hi,lo}, active-high.
- `cl_d`  in  NCLIENT×16: write data.
- `cl_q`  out  16: read data, shared by all clients. Valid in the cycle where that client's `cl_done` is high.
- `cl_done`  out  NCLIENT: one-cycle pulse to the granted client.
- `sd_req`  out  1: toggle request to the SDRAM controller.
- `sd_ack`  in  1: toggle acknowledge from the SDRAM controller.
- `sd_we`, `sd_a[21:1]`, `sd_ds[1:0]`, `sd_d[15:0]`  out: registered copies of the granted client's inputs.
- `sd_q`  in  16: read data. Valid once `sd_ack` equals `sd_req`.

## Operation
- States: DRAIN, IDLE, WAIT, DONE.
- DRAIN (state after reset):
  - Stay while `sd_ack != sd_req`.
  - Go to IDLE when they are equal.
  - No `cl_done` is generated; any read data in flight is discarded.
- IDLE:
  - If any `cl_req` is high, pick a winner `g`:
    - `PRIO0`=1 and `cl_req[0]` high: `g` = 0.
    - Otherwise `g` = first requester at or after `rr_ptr`, searching upward and wrapping.
  - Latch `g` and its `we/a/ds/d` onto the `sd_*` outputs, invert `sd_req`, and go to WAIT, all on the same edge.
- WAIT:
  - When `sd_ack == sd_req`: register `cl_q <= sd_q` (reads only; writes leave `cl_q` unchanged).
  - On the same edge, set `cl_done[g]`, set `rr_ptr <= (g+1) mod NCLIENT`, and go to DONE.
- DONE: clear `cl_done`, go to IDLE.
- The client must drop `cl_req` on the edge where it samples `cl_done`. A request still high in IDLE is treated as a new access.
- `sd_req` is not affected by `reset`. Its initial (power-up) value is 0. Toggle parity therefore survives a reset applied mid-access, and DRAIN absorbs the outstanding ack.
- `sd_*` outputs hold their value outside WAIT. The SDRAM controller samples them only at its RAS slot.
- Reset values:
  - state = DRAIN, `rr_ptr` = 0, `cl_done` = 0, `cl_q` = 0.
  - `sd_we` = 0, `sd_a` = 0, `sd_ds` = 0, `sd_d` = 0.

## Timing
- Request to grant: `cl_req` high before edge E0 in IDLE → `sd_req` toggles at E0.
- Access latency: `cl_done` is high 1 cycle after the edge where `sd_ack == sd_req` is sampled.
- SDRAM controller timing:
  - Idle controller, write: ack about 3 cycles after the request.
  - Idle controller, read: ack about 6 cycles after the request.
  - Worst case under refresh: about 12 cycles.
- Turnaround: there is one DONE cycle plus one IDLE sample between accesses. Back-to-back grants are therefore spaced by the access time + 2 cycles.
- Simultaneous requests in IDLE: exactly one grant. The losers stay pending and are served in round-robin order. A client waits at most `NCLIENT-1` accesses (client ≥1 under `PRIO0`=1 may starve; this is documented, not guarded).
- A `cl_req` that rises during WAIT or DONE is sampled in the next IDLE. It is never lost.
- A `reset` asserted in any state forces DRAIN on the next edge, and `cl_done` is low from that edge on.

## Structure
- Package `sdram_arb_pkg`:
  - state enum `arb_state_t` {DRAIN, IDLE, WAIT, DONE}.
  - `MAX_CLIENT` = 4.
  - address width constant `SD_AW` = 21.
- Sub-module `rr_picker`: combinational. Inputs `req[NCLIENT]`, `ptr`, `prio0`. Outputs `gnt_idx` and `any`.
- Everything else sits in `sdram_arbiter`: FSM, latches and `rr_ptr`.

## Test plan
Use a behavioural SDRAM model with a toggle ack and a programmable delay of 3–12 cycles.
- Single read, client 1, `a`=0x012345, model returns 0xBEEF after 6 cycles → `sd_a`=0x012345, `cl_done[1]` pulses once, `cl_q`=0xBEEF in that cycle.
- All three clients request together, `PRIO0`=0 → grant order 0,1,2. Repeated with `rr_ptr`=2: order 2,0,1.
- `PRIO0`=1, client 0 re-requests continuously alongside client 2 → client 0 served every time, client 2 only once client 0 drops.
- Write from client 2, `ds`=2'b10, `d`=0x5A00 → `sd_we`=1, `sd_ds`=2'b10, `sd_d`=0x5A00. `cl_done[2]` pulses and `cl_q` is unchanged.
- `reset` asserted 2 cycles after `sd_req` toggles; model acks 4 cycles later → no `cl_done`, FSM stays in DRAIN until the ack, next request is served normally with correct parity.
- Client holds `cl_req` one cycle past `cl_done` → second access issued; a correct client produces no duplicate access.
